// File: rtl/sump_readout_ctrl.sv
// sump_readout_ctrl: newest-first readback of captured samples from sample RAM to the UART transmitter.
// Optional feature: define READOUT_ABORT_EN to add the abort_i cancel input.
module sump_readout_ctrl #(
    parameter int WORD_BITS = 8,
    parameter int CMD_WORDS = 4,
    parameter int ADDR_BITS = 10
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [ADDR_BITS-1:0]           ptr_i,
    input  logic [ADDR_BITS:0]             cnt_i,
    input  logic [CMD_WORDS-1:0]           grp_en_i,
    output logic                           mem_rd_o,
    output logic [ADDR_BITS-1:0]           mem_addr_o,
    input  logic [CMD_WORDS*WORD_BITS-1:0] mem_data_i,
    output logic                           tx_stb_o,
    input  logic                           tx_rdy_i,
`ifdef READOUT_ABORT_EN
    input  logic                           abort_i,
`endif
    output logic [CMD_WORDS*WORD_BITS-1:0] tx_data_o,
    output logic [CMD_WORDS-1:0]           tx_sel_o,
    output logic                           busy_o,
    output logic                           done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_WAIT = 2'd2,
        ST_SEND = 2'd3
    } state_t;

    localparam logic [ADDR_BITS:0]   REM_ONE  = (ADDR_BITS+1)'(1'b1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1'b1);

    state_t                 state_r;
    logic [ADDR_BITS-1:0]   addr_r;
    logic [ADDR_BITS:0]     rem_r;
    logic                   abort_s;
    logic                   last_s;
    logic                   start_ok_s;

`ifdef READOUT_ABORT_EN
    assign abort_s = abort_i;
`else
    assign abort_s = 1'b0;
`endif

    assign last_s     = (rem_r == REM_ONE);
    assign start_ok_s = (cnt_i != '0) && (grp_en_i != '0);

    // Readout sequencer: all outputs are registered and driven from this block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            addr_r     <= '0;
            rem_r      <= '0;
            mem_rd_o   <= 1'b0;
            mem_addr_o <= '0;
            tx_stb_o   <= 1'b0;
            tx_data_o  <= '0;
            tx_sel_o   <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else if (abort_s && (state_r != ST_IDLE)) begin
            // Cancelled readout ends silently: no done pulse.
            state_r  <= ST_IDLE;
            mem_rd_o <= 1'b0;
            tx_stb_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_i && !abort_s) begin
                        if (start_ok_s) begin
                            addr_r     <= ptr_i;
                            rem_r      <= cnt_i;
                            tx_sel_o   <= grp_en_i;
                            mem_addr_o <= ptr_i;
                            mem_rd_o   <= 1'b1;
                            busy_o     <= 1'b1;
                            state_r    <= ST_READ;
                        end else begin
                            // Nothing to send: acknowledge immediately.
                            done_o <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    mem_rd_o <= 1'b0;
                    state_r  <= ST_WAIT;
                end
                ST_WAIT: begin
                    tx_data_o <= mem_data_i;
                    tx_stb_o  <= 1'b1;
                    state_r   <= ST_SEND;
                end
                ST_SEND: begin
                    if (tx_rdy_i) begin
                        tx_stb_o <= 1'b0;
                        rem_r    <= rem_r - REM_ONE;
                        addr_r   <= addr_r - ADDR_ONE;
                        if (last_s) begin
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            // Address wraps naturally through the modulo subtraction.
                            mem_addr_o <= addr_r - ADDR_ONE;
                            mem_rd_o   <= 1'b1;
                            state_r    <= ST_READ;
                        end
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_rd_o <= 1'b0;
                    tx_stb_o <= 1'b0;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sump_readout_ctrl.sv
// Self-checking bench for sump_readout_ctrl: randomized readouts against a newest-first address/data model.
`timescale 1ns/1ps
module tb_sump_readout_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  ptr;
    logic [10:0] cnt;
    logic [3:0]  grp;
    logic        mem_rd;
    logic [9:0]  mem_addr;
    logic [31:0] mem_data;
    logic        tx_stb;
    logic        tx_rdy;
    logic [31:0] tx_data;
    logic [3:0]  tx_sel;
    logic        busy;
    logic        done;
`ifdef READOUT_ABORT_EN
    logic        abort;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] mem [0:1023];

    sump_readout_ctrl #(.WORD_BITS(8), .CMD_WORDS(4), .ADDR_BITS(10)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .ptr_i(ptr), .cnt_i(cnt),
        .grp_en_i(grp), .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_data_i(mem_data),
        .tx_stb_o(tx_stb), .tx_rdy_i(tx_rdy),
`ifdef READOUT_ABORT_EN
        .abort_i(abort),
`endif
        .tx_data_o(tx_data), .tx_sel_o(tx_sel), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    // Synchronous sample RAM; garbage when not read so mistimed capture shows up.
    always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : $urandom;

    task automatic run_readout(input logic [9:0] p, input logic [10:0] n, input logic [3:0] m,
                               input int mode, input bit stray);
        int cyc, reads, xfers, last_x, last_rd, hold, budget;
        bit done_seen, prev_hold, prev_stb;
        logic [31:0] hd;
        logic [3:0] hs;
        logic [9:0] ea;
        budget = int'(n) * 45 + 100;
        @(negedge clk);
        start = 1'b1; ptr = p; cnt = n; grp = m; tx_rdy = 1'b0;
        @(negedge clk);
        start = 1'b0; ptr = 10'($urandom_range(0, 1023)); cnt = 11'($urandom_range(0, 2047));
        grp = 4'($urandom_range(0, 15));
        cyc = 1; reads = 0; xfers = 0; last_x = -100; last_rd = -100; hold = 0;
        done_seen = 1'b0; prev_hold = 1'b0; prev_stb = 1'b0; hd = '0; hs = '0;
        while (!done_seen && cyc < budget) begin
            if (cyc == 1) begin
                checks++;
                if (mem_rd !== 1'b1 || mem_addr !== p)
                    $display("FAIL first_read: rd=%b addr=%0d required rd=1 addr=%0d", mem_rd, mem_addr, p);
            end
            if (mem_rd === 1'b1) begin
                ea = p - 10'(reads);
                checks++;
                if (mem_addr !== ea) begin
                    failures++;
                    $display("FAIL rd_addr: got %0d required %0d (read #%0d)", mem_addr, ea, reads);
                end
                checks++;
                if (reads != xfers || (reads > 0 && cyc != last_x + 1)) begin
                    failures++;
                    $display("FAIL rd_timing: read #%0d at cycle %0d, transfers=%0d last transfer cycle %0d",
                             reads, cyc, xfers, last_x);
                end
                reads++; last_rd = cyc;
            end
            if (tx_stb === 1'b1 && !prev_stb) begin
                checks++;
                if (cyc != last_rd + 2) begin
                    failures++;
                    $display("FAIL stb_latency: stb at cycle %0d required %0d", cyc, last_rd + 2);
                end
            end
            if (prev_hold) begin
                checks++;
                if (tx_stb !== 1'b1 || tx_data !== hd || tx_sel !== hs) begin
                    failures++;
                    $display("FAIL hold_stable: stb=%b data=%h sel=%b required stb=1 data=%h sel=%b",
                             tx_stb, tx_data, tx_sel, hd, hs);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (xfers != int'(n) || cyc != last_x + 1 || busy !== 1'b0 || tx_stb !== 1'b0) begin
                    failures++;
                    $display("FAIL done: transfers=%0d required %0d, cycle %0d required %0d, busy=%b stb=%b",
                             xfers, n, cyc, last_x + 1, busy, tx_stb);
                end
                done_seen = 1'b1;
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy: got %b required 1 at cycle %0d", busy, cyc);
                end
            end
            case (mode)
                0:       tx_rdy = 1'b1;
                1:       tx_rdy = 1'($urandom_range(0, 1));
                default: tx_rdy = (hold >= 20);
            endcase
            if (tx_stb === 1'b1 && !tx_rdy) hold++;
            prev_hold = (tx_stb === 1'b1) && !tx_rdy;
            if (tx_stb === 1'b1 && tx_rdy) begin
                ea = p - 10'(xfers);
                checks++;
                if (tx_data !== mem[ea] || tx_sel !== m) begin
                    failures++;
                    $display("FAIL xfer_data: #%0d data=%h sel=%b required data=%h sel=%b",
                             xfers, tx_data, tx_sel, mem[ea], m);
                end
                xfers++; last_x = cyc;
            end
            hd = tx_data; hs = tx_sel; prev_stb = (tx_stb === 1'b1);
            if (stray && cyc == 2) begin
                start = 1'b1; ptr = 10'd100; cnt = 11'd3; grp = 4'b0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL timeout: no done within %0d cycles (transfers=%0d of %0d)", budget, xfers, n);
        end
        tx_rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({done, mem_rd, tx_stb, busy} !== 4'b0000) begin
                failures++;
                $display("FAIL post_done: done=%b rd=%b stb=%b busy=%b required all 0", done, mem_rd, tx_stb, busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_rd, mem_addr, tx_stb, tx_data, tx_sel, busy, done} !== 50'd0) begin
            failures++;
            $display("FAIL reset_values: rd=%b addr=%0d stb=%b data=%h sel=%b busy=%b done=%b required all 0",
                     mem_rd, mem_addr, tx_stb, tx_data, tx_sel, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        run_readout(10'd5, 11'd1, 4'b1111, 0, 1'b0);
    endtask

    task automatic test_wrap();
        run_readout(10'd1, 11'd4, 4'b1010, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_readout(10'd300, 11'd3, 4'b0110, 2, 1'b0);
    endtask

    task automatic test_degenerate(input logic [10:0] n, input logic [3:0] m);
        @(negedge clk);
        start = 1'b1; ptr = 10'd42; cnt = n; grp = m;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, busy, mem_rd, tx_stb} !== 4'b1000) begin
            failures++;
            $display("FAIL degenerate_done: done=%b busy=%b rd=%b stb=%b required 1000 (cnt=%0d mask=%b)",
                     done, busy, mem_rd, tx_stb, n, m);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({done, busy, mem_rd, tx_stb} !== 4'b0000) begin
                failures++;
                $display("FAIL degenerate_quiet: done=%b busy=%b rd=%b stb=%b required 0000", done, busy, mem_rd, tx_stb);
            end
        end
    endtask

    task automatic test_start_while_busy();
        run_readout(10'd700, 11'd5, 4'b0011, 1, 1'b1);
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        start = 1'b1; ptr = 10'd7; cnt = 11'd5; grp = 4'b1111; tx_rdy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({mem_rd, mem_addr, tx_stb, tx_data, tx_sel, busy, done} !== 50'd0) begin
            failures++;
            $display("FAIL reset_midop: rd=%b addr=%0d stb=%b data=%h sel=%b busy=%b done=%b required all 0",
                     mem_rd, mem_addr, tx_stb, tx_data, tx_sel, busy, done);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({done, busy, mem_rd, tx_stb} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_quiet: done=%b busy=%b rd=%b stb=%b required 0000", done, busy, mem_rd, tx_stb);
            end
        end
        tx_rdy = 1'b0;
    endtask

`ifdef READOUT_ABORT_EN
    task automatic test_abort();
        @(negedge clk);
        start = 1'b1; ptr = 10'd9; cnt = 11'd3; grp = 4'b1111; tx_rdy = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_stb !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup: stb=%b required 1", tx_stb);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({done, busy, mem_rd, tx_stb} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_idle: done=%b busy=%b rd=%b stb=%b required 0000", done, busy, mem_rd, tx_stb);
        end
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({done, busy, mem_rd} !== 3'b000) begin
            failures++;
            $display("FAIL abort_start: done=%b busy=%b rd=%b required 000", done, busy, mem_rd);
        end
        run_readout(10'd9, 11'd3, 4'b1111, 0, 1'b0);
    endtask
`endif

    task automatic test_random();
        for (int t = 0; t < 6; t++)
            run_readout(10'($urandom_range(0, 1023)), 11'($urandom_range(1, 40)),
                        4'($urandom_range(1, 15)), 1, 1'b0);
    endtask

    task automatic test_long_wrap();
        run_readout(10'd3, 11'd1030, 4'b1001, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ptr = '0; cnt = '0; grp = '0; tx_rdy = 1'b0;
`ifdef READOUT_ABORT_EN
        abort = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[5] = 32'hDEADBEEF;
        test_reset();
        test_single();
        test_wrap();
        test_backpressure();
        test_degenerate(11'd0, 4'b1111);
        test_degenerate(11'd5, 4'b0000);
        test_start_while_busy();
        test_reset_midop();
`ifdef READOUT_ABORT_EN
        test_abort();
`endif
        test_random();
        test_long_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
